// File: rtl/regfile_writeback_pkg.sv
// Shared defaults and types for the register-file write-back front end.
package regfile_writeback_pkg;

    localparam int WB_DW    = 32;
    localparam int WB_AW    = 5;
    localparam int REG_ZERO = 0;

    typedef struct packed {
        logic             we;
        logic [WB_AW-1:0] addr;
        logic [WB_DW-1:0] data;
    } wb_port_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_FIFO,
        SRC_BYPASS
    } wb_src_e;

endpackage

// File: rtl/regfile_writeback_fifo.sv
// Small FIFO of {rd, data} load responses that lost write-port arbitration.
// Depth must be a power of two so the pointers wrap on their own.
module wb_load_fifo #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [AW-1:0] push_rd_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output logic [AW-1:0] head_rd_o,
    output logic [DW-1:0] head_data_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0] rd_mem   [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q,  count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push_i && !pop_i) begin
            count_d = count_q + (PW+1)'(1);
        end else if (pop_i && !push_i) begin
            count_d = count_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            rd_mem[wr_ptr_q]   <= push_rd_i;
            data_mem[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_rd_o   = rd_mem[rd_ptr_q];
    assign head_data_o = data_mem[rd_ptr_q];
    assign full_o      = (count_q == (PW+1)'(DEPTH));
    assign empty_o     = (count_q == '0);

endmodule

// File: rtl/regfile_writeback.sv
// Write-port arbiter for the register file: ALU results beat buffered loads,
// which beat a bypassed load; also tracks which registers await a load.
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter int DW    = WB_DW,
    parameter int AW    = WB_AW,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_rd,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_rd,
    input  logic [DW-1:0] alu_data,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [AW-1:0] ld_rd,
    input  logic [DW-1:0] ld_data,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    input  logic [AW-1:0] q1_addr,
    output logic          q1_busy,
    input  logic [AW-1:0] q2_addr,
    output logic          q2_busy
);

    localparam int NREG = 1 << AW;

    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [AW-1:0] head_rd;
    logic [DW-1:0] head_data;
    logic          ld_acc;
    wb_src_e       src;
    logic [AW-1:0] sel_rd;
    logic [DW-1:0] sel_data;

    logic            we_q,    we_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [NREG-1:0] busy_q,  busy_d;

    wb_load_fifo #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_rd_i   (ld_rd),
        .push_data_i (ld_data),
        .pop_i       (fifo_pop),
        .head_rd_o   (head_rd),
        .head_data_o (head_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign ld_ready = !fifo_full;
    assign ld_acc   = ld_valid && ld_ready;

    // A load may only bypass the buffer when nothing older is waiting in it.
    always_comb begin
        src      = SRC_NONE;
        sel_rd   = alu_rd;
        sel_data = alu_data;
        if (alu_valid) begin
            src = SRC_ALU;
        end else if (!fifo_empty) begin
            src      = SRC_FIFO;
            sel_rd   = head_rd;
            sel_data = head_data;
        end else if (ld_acc) begin
            src      = SRC_BYPASS;
            sel_rd   = ld_rd;
            sel_data = ld_data;
        end
    end

    assign fifo_pop  = (src == SRC_FIFO);
    assign fifo_push = ld_acc && (src != SRC_BYPASS);

    always_comb begin
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (src != SRC_NONE) begin
            we_d    = (sel_rd != AW'(REG_ZERO));
            waddr_d = sel_rd;
            wdata_d = sel_data;
        end
    end

    // Set is applied after clear so a same-cycle reissue keeps the bit.
    always_comb begin
        busy_d = busy_q;
        if (src == SRC_FIFO || src == SRC_BYPASS) begin
            busy_d[sel_rd] = 1'b0;
        end
        if (iss_valid) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            busy_q  <= '0;
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
        end
    end

    assign we      = we_q;
    assign waddr   = waddr_q;
    assign wdata   = wdata_q;
    assign q1_busy = busy_q[q1_addr];
    assign q2_busy = busy_q[q2_addr];

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: a vector table for the steady-state
// cases plus a hand-written mid-operation reset sequence.
module tb_regfile_writeback;
    import regfile_writeback_pkg::*;

    localparam logic N = 1'b0;
    localparam logic Y = 1'b1;
    localparam int   NV = 22;

    typedef struct {
        logic        iss_v;
        logic [4:0]  iss_rd;
        logic        alu_v;
        logic [4:0]  alu_rd;
        logic [31:0] alu_data;
        logic        ld_v;
        logic [4:0]  ld_rd;
        logic [31:0] ld_data;
        logic [4:0]  q1;
        logic [4:0]  q2;
        wb_port_t    exp;
        logic        exp_q1;
        logic        exp_q2;
        logic        exp_rdy;
        logic        chk_addr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  q1_addr;
    logic        q1_busy;
    logic [4:0]  q2_addr;
    logic        q2_busy;

    int   nChecks = 0;
    int   nFails  = 0;
    vec_t vecs [NV];

    regfile_writeback dut (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_rd     (ld_rd),
        .ld_data   (ld_data),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .q1_addr   (q1_addr),
        .q1_busy   (q1_busy),
        .q2_addr   (q2_addr),
        .q2_busy   (q2_busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic setIdle();
        iss_valid = 1'b0;
        iss_rd    = 5'd0;
        alu_valid = 1'b0;
        alu_rd    = 5'd0;
        alu_data  = 32'h0;
        ld_valid  = 1'b0;
        ld_rd     = 5'd0;
        ld_data   = 32'h0;
    endtask

    task automatic applyStimulus(input vec_t v);
        iss_valid = v.iss_v;
        iss_rd    = v.iss_rd;
        alu_valid = v.alu_v;
        alu_rd    = v.alu_rd;
        alu_data  = v.alu_data;
        ld_valid  = v.ld_v;
        ld_rd     = v.ld_rd;
        ld_data   = v.ld_data;
        q1_addr   = v.q1;
        q2_addr   = v.q2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        //         iss        alu                  ld                   q1     q2     {we, addr, data}          q1b q2b rdy chk
        vecs[0]  = '{N, 5'd0, Y, 5'd3,  32'h1234, N, 5'd0, 32'h0,    5'd5,  5'd3,  '{Y, 5'd3,  32'h1234}, N, N, Y, Y};
        vecs[1]  = '{N, 5'd0, N, 5'd0,  32'h0,    N, 5'd0, 32'h0,    5'd5,  5'd3,  '{N, 5'd3,  32'h1234}, N, N, Y, Y};
        vecs[2]  = '{Y, 5'd5, N, 5'd0,  32'h0,    N, 5'd0, 32'h0,    5'd5,  5'd3,  '{N, 5'd3,  32'h1234}, Y, N, Y, Y};
        vecs[3]  = '{N, 5'd0, N, 5'd0,  32'h0,    Y, 5'd5, 32'hCAFE, 5'd5,  5'd3,  '{Y, 5'd5,  32'hCAFE}, N, N, Y, Y};
        vecs[4]  = '{Y, 5'd2, N, 5'd0,  32'h0,    N, 5'd0, 32'h0,    5'd2,  5'd1,  '{N, 5'd5,  32'hCAFE}, Y, N, Y, Y};
        vecs[5]  = '{N, 5'd0, Y, 5'd1,  32'h11,   Y, 5'd2, 32'h22,   5'd2,  5'd1,  '{Y, 5'd1,  32'h11},   Y, N, Y, Y};
        vecs[6]  = '{N, 5'd0, N, 5'd0,  32'h0,    N, 5'd0, 32'h0,    5'd2,  5'd1,  '{Y, 5'd2,  32'h22},   N, N, Y, Y};
        vecs[7]  = '{N, 5'd0, N, 5'd0,  32'h0,    N, 5'd0, 32'h0,    5'd2,  5'd1,  '{N, 5'd2,  32'h22},   N, N, Y, Y};
        vecs[8]  = '{Y, 5'd6, N, 5'd0,  32'h0,    N, 5'd0, 32'h0,    5'd6,  5'd7,  '{N, 5'd2,  32'h22},   Y, N, Y, Y};
        vecs[9]  = '{Y, 5'd7, N, 5'd0,  32'h0,    N, 5'd0, 32'h0,    5'd6,  5'd7,  '{N, 5'd2,  32'h22},   Y, Y, Y, Y};
        vecs[10] = '{Y, 5'd8, N, 5'd0,  32'h0,    N, 5'd0, 32'h0,    5'd8,  5'd6,  '{N, 5'd2,  32'h22},   Y, Y, Y, Y};
        vecs[11] = '{N, 5'd0, Y, 5'd10, 32'hA0,   Y, 5'd6, 32'h66,   5'd6,  5'd8,  '{Y, 5'd10, 32'hA0},   Y, Y, Y, Y};
        vecs[12] = '{N, 5'd0, Y, 5'd11, 32'hA1,   Y, 5'd7, 32'h77,   5'd7,  5'd8,  '{Y, 5'd11, 32'hA1},   Y, Y, N, Y};
        vecs[13] = '{N, 5'd0, Y, 5'd12, 32'hA2,   Y, 5'd8, 32'h88,   5'd7,  5'd8,  '{Y, 5'd12, 32'hA2},   Y, Y, N, Y};
        vecs[14] = '{N, 5'd0, Y, 5'd13, 32'hA3,   Y, 5'd8, 32'h88,   5'd6,  5'd8,  '{Y, 5'd13, 32'hA3},   Y, Y, N, Y};
        vecs[15] = '{N, 5'd0, N, 5'd0,  32'h0,    Y, 5'd8, 32'h88,   5'd6,  5'd8,  '{Y, 5'd6,  32'h66},   N, Y, Y, Y};
        vecs[16] = '{N, 5'd0, N, 5'd0,  32'h0,    Y, 5'd8, 32'h88,   5'd7,  5'd8,  '{Y, 5'd7,  32'h77},   N, Y, Y, Y};
        vecs[17] = '{N, 5'd0, N, 5'd0,  32'h0,    N, 5'd0, 32'h0,    5'd8,  5'd6,  '{Y, 5'd8,  32'h88},   N, N, Y, Y};
        vecs[18] = '{N, 5'd0, N, 5'd0,  32'h0,    N, 5'd0, 32'h0,    5'd8,  5'd6,  '{N, 5'd8,  32'h88},   N, N, Y, Y};
        vecs[19] = '{N, 5'd0, Y, 5'd0,  32'h44,   Y, 5'd0, 32'h55,   5'd0,  5'd0,  '{N, 5'd0,  32'h0},    N, N, Y, N};
        vecs[20] = '{Y, 5'd0, N, 5'd0,  32'h0,    N, 5'd0, 32'h0,    5'd0,  5'd0,  '{N, 5'd0,  32'h0},    N, N, Y, N};
        vecs[21] = '{N, 5'd0, N, 5'd0,  32'h0,    N, 5'd0, 32'h0,    5'd0,  5'd0,  '{N, 5'd0,  32'h0},    N, N, Y, N};

        rst = 1'b1;
        setIdle();
        q1_addr = 5'd5;
        q2_addr = 5'd3;
        #2;
        checkOutput("reset we", 32'(we), 32'h0);
        checkOutput("reset waddr", 32'(waddr), 32'h0);
        checkOutput("reset wdata", wdata, 32'h0);
        checkOutput("reset ld_ready", 32'(ld_ready), 32'h1);
        checkOutput("reset q1_busy", 32'(q1_busy), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step();

        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i]);
            step();
            checkOutput($sformatf("vec%0d we", i), 32'(we), 32'(vecs[i].exp.we));
            if (vecs[i].chk_addr) begin
                checkOutput($sformatf("vec%0d waddr", i), 32'(waddr), 32'(vecs[i].exp.addr));
                checkOutput($sformatf("vec%0d wdata", i), wdata, vecs[i].exp.data);
            end
            checkOutput($sformatf("vec%0d q1_busy", i), 32'(q1_busy), 32'(vecs[i].exp_q1));
            checkOutput($sformatf("vec%0d q2_busy", i), 32'(q2_busy), 32'(vecs[i].exp_q2));
            checkOutput($sformatf("vec%0d ld_ready", i), 32'(ld_ready), 32'(vecs[i].exp_rdy));
        end

        // Fill the buffer behind an ALU burst, then reset in the middle of a cycle.
        setIdle();
        q1_addr   = 5'd20;
        q2_addr   = 5'd21;
        iss_valid = 1'b1;
        iss_rd    = 5'd20;
        step();
        iss_rd    = 5'd21;
        step();
        setIdle();
        alu_valid = 1'b1;
        alu_rd    = 5'd1;
        alu_data  = 32'hB1;
        ld_valid  = 1'b1;
        ld_rd     = 5'd20;
        ld_data   = 32'h2020;
        step();
        alu_data  = 32'hB2;
        ld_rd     = 5'd21;
        ld_data   = 32'h2121;
        step();
        checkOutput("full ld_ready", 32'(ld_ready), 32'h0);
        checkOutput("full we", 32'(we), 32'h1);
        checkOutput("full wdata", wdata, 32'hB2);
        checkOutput("full q1_busy", 32'(q1_busy), 32'h1);
        checkOutput("full q2_busy", 32'(q2_busy), 32'h1);
        ld_valid  = 1'b0;
        alu_data  = 32'hB3;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst we", 32'(we), 32'h0);
        checkOutput("midrst waddr", 32'(waddr), 32'h0);
        checkOutput("midrst wdata", wdata, 32'h0);
        checkOutput("midrst ld_ready", 32'(ld_ready), 32'h1);
        checkOutput("midrst q1_busy", 32'(q1_busy), 32'h0);
        checkOutput("midrst q2_busy", 32'(q2_busy), 32'h0);
        setIdle();
        @(negedge clk);
        rst = 1'b0;
        step();
        checkOutput("postrst idle we", 32'(we), 32'h0);
        checkOutput("postrst idle ld_ready", 32'(ld_ready), 32'h1);

        alu_valid = 1'b1;
        alu_rd    = 5'd9;
        alu_data  = 32'h99;
        step();
        checkOutput("postrst alu we", 32'(we), 32'h1);
        checkOutput("postrst alu waddr", 32'(waddr), 32'd9);
        checkOutput("postrst alu wdata", wdata, 32'h99);

        setIdle();
        q1_addr   = 5'd4;
        iss_valid = 1'b1;
        iss_rd    = 5'd4;
        step();
        checkOutput("postrst iss q1_busy", 32'(q1_busy), 32'h1);
        checkOutput("postrst iss we", 32'(we), 32'h0);

        setIdle();
        ld_valid  = 1'b1;
        ld_rd     = 5'd4;
        ld_data   = 32'h4444;
        step();
        checkOutput("postrst ld we", 32'(we), 32'h1);
        checkOutput("postrst ld waddr", 32'(waddr), 32'd4);
        checkOutput("postrst ld wdata", wdata, 32'h4444);
        checkOutput("postrst ld q1_busy", 32'(q1_busy), 32'h0);
        setIdle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Writer-side front end for the 32x32 register file. It arbitrates ALU results and load responses onto the file's single write port (we/waddr/wdata).
- Buffers load responses that collide with ALU results.
- Keeps a per-register pending-load scoreboard that decode queries for interlock.
- Sits between the MEM/ALU stages and the register file.

Parameters:
- DW, 32, data width
- AW, 5, register address width (2**AW registers)
- DEPTH, 2, load-response buffer entries (power of 2, >=2)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- iss_valid  in  1  decode issues a load this cycle
- iss_rd  in  AW  destination of the issued load
- alu_valid  in  1  ALU result valid; never back-pressured
- alu_rd  in  AW  ALU destination
- alu_data  in  DW  ALU result
- ld_valid  in  1  load response valid
- ld_ready  out  1  load response accepted when ld_valid&&ld_ready
- ld_rd  in  AW  load destination
- ld_data  in  DW  load data
- we  out  1  register-file write enable (registered)
- waddr  out  AW  register-file write address (registered)
- wdata  out  DW  register-file write data (registered)
- q1_addr  in  AW  scoreboard query 1
- q1_busy  out  1  q1_addr has a pending load
- q2_addr  in  AW  scoreboard query 2
- q2_busy  out  1  q2_addr has a pending load

Behaviour:
- Reset (async, immediate): we=0, waddr=0, wdata=0, all busy bits 0, buffer empty.
- ld_ready = (count < DEPTH); combinational; 1 out of reset.
- Write-port arbitration each posedge, priority high to low:
  - alu_valid
  - buffer head
  - incoming accepted load (bypass, only when buffer empty)
- The winner drives we/waddr/wdata in the next cycle.
- Latency: ALU or uncontested load presented in cycle N -> we=1 during cycle N+1. The register file commits on the negedge of N+1.
- Losing accepted loads are pushed to the buffer tail. Buffer is FIFO; order of loads is preserved.
- Same-cycle push and pop are allowed; count is unchanged. Full buffer: ld_ready=0, ld_valid ignored.
- No candidate: we=0; waddr/wdata hold their last values.
- Destination 0: the write-port slot is consumed but we=0 (r0 never written). A load to r0 never sets busy.
- Scoreboard busy[31:0]:
  - Set on iss_valid for iss_rd.
  - Cleared on the edge that registers the load's write (we asserted for that load).
  - Set and clear on the same register in the same cycle: set wins.
  - qN_busy = busy[qN_addr], registered bits only; no bypass of same-cycle set/clear.
- Protocol rules (decode guarantees; bench asserts):
  - No iss_valid to a register that is already busy.
  - No alu_valid to a busy register.
  - At most one outstanding load per register.
- Reset mid-operation: the buffer is discarded, busy is cleared, and we drops asynchronously.

Decomposition:
- Shared package: DW/AW defaults, REG_ZERO constant, write-port struct {we, addr, data}.
- Natural sub-module: wb_load_fifo (DEPTH-entry FIFO of {rd,data}, with push/pop/count/full/empty).
- The top level holds the arbiter, the output register and the scoreboard.

Test Plan:
- Reset, then alu_valid rd=3 data=0x1234 in cycle N -> we=1, waddr=3, wdata=0x1234 in N+1; we=0 in N+2.
- iss_valid rd=5 -> q1_busy(5)=1 next cycle. Then ld_valid rd=5 data=0xCAFE alone -> written at N+1; busy[5]=0 after that edge.
- ALU rd=1 and load rd=2 in the same cycle -> rd=1 written N+1, rd=2 written N+2 from the buffer, busy[2] clears at N+2's edge.
- ALU valid for 4 consecutive cycles while loads rd=6,7,8 arrive -> ld_ready=0 after 2 buffered. Loads are written 6 then 7 then 8 after the ALU burst; no loss or reorder.
- Load response to rd=0 and ALU to rd=0 -> we stays 0; busy[0] never set.
- rst asserted mid-burst with a full buffer -> we=0 immediately, ld_ready=1, all qN_busy=0; post-reset writes are correct.
